// File: rtl/uart_boot_sequencer_pkg.sv
// Shared definitions for the UART boot sequencer: state encodings and protocol bytes.
package uart_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE    = 3'd0,
        BOOT_SEND_99 = 3'd1,
        BOOT_RX_SIZE = 3'd2,
        BOOT_RX_PROG = 3'd3,
        BOOT_SEND_AA = 3'd4,
        BOOT_RUN     = 3'd5,
        BOOT_ERROR   = 3'd6
    } boot_state_t;

    localparam logic [7:0] BOOT_START_BYTE = 8'h99;
    localparam logic [7:0] BOOT_DONE_BYTE  = 8'hAA;

endpackage

// File: rtl/uart_boot_sequencer_boot_cycle_timer.sv
// Boot cycle timer: loadable 32-bit down-counter that stops at zero and flags done.
module uart_boot_sequencer_boot_cycle_timer #(
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        enable,
    output logic        done
);

    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'(RESET_VALUE);
        end else if (load) begin
            count_q <= load_value;
        end else if (enable && (count_q != 32'd0)) begin
            count_q <= count_q - 32'd1;
        end
    end

    assign done = (count_q == 32'd0);

endmodule

// File: rtl/uart_boot_sequencer.sv
// UART boot sequencer: drives the 0x99 / size / program / 0xAA handshake, then releases the CPU.
// Optional receive-phase watchdog enabled by defining UART_BOOT_TIMEOUT_EN.
module uart_boot_sequencer
    import uart_boot_sequencer_pkg::*;
#(
    parameter int unsigned MAX_PROGRAM_BYTES  = 65536,
    parameter int unsigned START_DELAY_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES     = 100000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        transmit_0x99_finished,
    input  logic        receive_program_data_size_finished,
    input  logic        receive_program_data_finished,
    input  logic        transmit_0xAA_finished,
    input  logic [31:0] program_data_size,
    input  logic        program_memory_write_enable,
    output logic        transmit_0x99,
    output logic        receive_program_data_size,
    output logic        receive_program_data,
    output logic        transmit_0xAA,
    output logic        receive_stdin_data,
    output logic        transmit_stdout_data,
    output logic        cpu_run,
    output logic        boot_error,
    output logic [2:0]  boot_state,
    output logic [29:0] program_word_count
);

    localparam logic [2:0] ST_IDLE    = BOOT_IDLE;
    localparam logic [2:0] ST_SEND_99 = BOOT_SEND_99;
    localparam logic [2:0] ST_RX_SIZE = BOOT_RX_SIZE;
    localparam logic [2:0] ST_RX_PROG = BOOT_RX_PROG;
    localparam logic [2:0] ST_SEND_AA = BOOT_SEND_AA;
    localparam logic [2:0] ST_RUN     = BOOT_RUN;
    localparam logic [2:0] ST_ERROR   = BOOT_ERROR;

    logic [2:0]  state_q, state_d;
    logic [31:0] size_q;
    logic [29:0] word_count_q;
    logic        settle_q;
    logic        start_done;
    logic        timeout;
    logic        in_rx;

    assign in_rx = (state_q == ST_RX_SIZE) || (state_q == ST_RX_PROG);

    // Counter resets to the delay, so a delay of 0 leaves IDLE on the first edge.
    uart_boot_sequencer_boot_cycle_timer #(
        .RESET_VALUE (START_DELAY_CYCLES)
    ) u_start_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (1'b0),
        .load_value (32'd0),
        .enable     (state_q == ST_IDLE),
        .done       (start_done)
    );

`ifdef UART_BOOT_TIMEOUT_EN
    logic wd_load;
    logic wd_done;

    assign wd_load = ((state_d != state_q) &&
                      ((state_d == ST_RX_SIZE) || (state_d == ST_RX_PROG))) ||
                     ((state_q == ST_RX_PROG) && program_memory_write_enable);

    uart_boot_sequencer_boot_cycle_timer #(
        .RESET_VALUE (TIMEOUT_CYCLES)
    ) u_watchdog_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (wd_load),
        .load_value (32'(TIMEOUT_CYCLES)),
        .enable     (in_rx),
        .done       (wd_done)
    );

    assign timeout = wd_done && in_rx;
`else
    logic unused_timeout;
    assign unused_timeout = ^{TIMEOUT_CYCLES, in_rx};
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_done) state_d = ST_SEND_99;
            ST_SEND_99: if (transmit_0x99_finished) state_d = ST_RX_SIZE;
            ST_RX_SIZE: begin
                if (receive_program_data_size_finished) begin
                    if ((program_data_size > 32'(MAX_PROGRAM_BYTES)) ||
                        (program_data_size[1:0] != 2'b00)) begin
                        state_d = ST_ERROR;
                    end else if (program_data_size == 32'd0) begin
                        state_d = ST_SEND_AA;
                    end else begin
                        state_d = ST_RX_PROG;
                    end
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RX_PROG: begin
                // settle_q marks the cycle after the done flag, once the last strobe has landed.
                if (settle_q) begin
                    state_d = ({word_count_q, 2'b00} == size_q) ? ST_SEND_AA : ST_ERROR;
                end else if (!receive_program_data_finished && timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SEND_AA: if (transmit_0xAA_finished) state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            ST_ERROR:   state_d = ST_ERROR;
            default:    state_d = ST_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            size_q       <= 32'd0;
            word_count_q <= 30'd0;
            settle_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= (state_d == ST_RX_PROG) && receive_program_data_finished;
            if ((state_q == ST_RX_SIZE) && receive_program_data_size_finished) begin
                size_q <= program_data_size;
            end
            if ((state_q == ST_RX_PROG) && program_memory_write_enable && !(&word_count_q)) begin
                word_count_q <= word_count_q + 30'd1;
            end
        end
    end

    assign transmit_0x99             = (state_q == ST_SEND_99) && !transmit_0x99_finished;
    assign receive_program_data_size = (state_q == ST_RX_SIZE) &&
                                       !receive_program_data_size_finished;
    assign receive_program_data      = (state_q == ST_RX_PROG) && !receive_program_data_finished;
    assign transmit_0xAA             = (state_q == ST_SEND_AA) && !transmit_0xAA_finished;
    assign cpu_run                   = (state_q == ST_RUN);
    assign receive_stdin_data        = (state_q == ST_RUN);
    assign transmit_stdout_data      = (state_q == ST_RUN);
    assign boot_error                = (state_q == ST_ERROR);
    assign boot_state                = state_q;
    assign program_word_count        = word_count_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Self-checking bench for uart_boot_sequencer: vector table, random boots and a mid-load reset.
module tb_uart_boot_sequencer;

    localparam int unsigned DELAY   = 3;
    localparam int unsigned MAX_LEN = 65536;

    logic        clk;
    logic        reset_n;
    logic        transmit_0x99_finished;
    logic        receive_program_data_size_finished;
    logic        receive_program_data_finished;
    logic        transmit_0xAA_finished;
    logic [31:0] program_data_size;
    logic        program_memory_write_enable;
    logic        transmit_0x99;
    logic        receive_program_data_size;
    logic        receive_program_data;
    logic        transmit_0xAA;
    logic        receive_stdin_data;
    logic        transmit_stdout_data;
    logic        cpu_run;
    logic        boot_error;
    logic [2:0]  boot_state;
    logic [29:0] program_word_count;

    int total;
    int bad;

    uart_boot_sequencer #(
        .MAX_PROGRAM_BYTES  (MAX_LEN),
        .START_DELAY_CYCLES (DELAY),
        .TIMEOUT_CYCLES     (1000)
    ) dut (
        .clk                                (clk),
        .reset_n                            (reset_n),
        .transmit_0x99_finished             (transmit_0x99_finished),
        .receive_program_data_size_finished (receive_program_data_size_finished),
        .receive_program_data_finished      (receive_program_data_finished),
        .transmit_0xAA_finished             (transmit_0xAA_finished),
        .program_data_size                  (program_data_size),
        .program_memory_write_enable        (program_memory_write_enable),
        .transmit_0x99                      (transmit_0x99),
        .receive_program_data_size          (receive_program_data_size),
        .receive_program_data               (receive_program_data),
        .transmit_0xAA                      (transmit_0xAA),
        .receive_stdin_data                 (receive_stdin_data),
        .transmit_stdout_data               (transmit_stdout_data),
        .cpu_run                            (cpu_run),
        .boot_error                         (boot_error),
        .boot_state                         (boot_state),
        .program_word_count                 (program_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] size;
        int          strobes;
        bit          together;
        int          exp_state;
        int          exp_wc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Outcome of a boot from the protocol rules alone.
    task automatic model(input logic [31:0] size, input int strobes,
                         output int st, output int wc);
        if (size > MAX_LEN || (size % 4) != 0) begin
            st = 6; wc = 0;
        end else if (size == 0) begin
            st = 5; wc = 0;
        end else begin
            wc = strobes;
            st = (strobes * 4 == size) ? 5 : 6;
        end
    endtask

    function automatic logic [7:0] outs();
        return {cpu_run, receive_stdin_data, transmit_stdout_data, boot_error,
                receive_program_data, transmit_0x99, receive_program_data_size, transmit_0xAA};
    endfunction

    task automatic clear_inputs();
        transmit_0x99_finished             = 1'b0;
        receive_program_data_size_finished = 1'b0;
        receive_program_data_finished      = 1'b0;
        transmit_0xAA_finished             = 1'b0;
        program_data_size                  = 32'd0;
        program_memory_write_enable        = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (boot_state == 3'd0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, DELAY + 1);
        chk("state_send99", boot_state, 1);
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_outs", {outs(), 5'd0, boot_state}, 16'd0);
        chk("reset_wc", program_word_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_boot(input logic [31:0] size, input int strobes, input bit together,
                            output int st, output int wc);
        int gap;
        int highs;
        apply_reset();
        wait_idle("idle_len");
        gap = $urandom_range(0, 3);
        highs = 0;
        repeat (gap) begin
            if (transmit_0x99) highs++;
            @(negedge clk);
        end
        transmit_0x99_finished = 1'b1;
        #1;
        chk("tx99_gated", transmit_0x99, 0);
        chk("tx99_high_cycles", highs, gap);
        @(negedge clk);
        chk("state_rxsize", boot_state, 2);
        chk("rxsize_req", receive_program_data_size, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        program_data_size = size;
        receive_program_data_size_finished = 1'b1;
        #1;
        chk("rxsize_gated", receive_program_data_size, 0);
        @(negedge clk);
        if (boot_state == 3'd3) begin
            chk("rxprog_req", receive_program_data, 1);
            for (int j = 0; j < strobes; j++) begin
                program_memory_write_enable = 1'b1;
                if (together && j == strobes - 1) receive_program_data_finished = 1'b1;
                @(negedge clk);
                program_memory_write_enable = 1'b0;
                if (!receive_program_data_finished && $urandom_range(0, 1) == 1) @(negedge clk);
            end
            if (!receive_program_data_finished) begin
                receive_program_data_finished = 1'b1;
                #1;
                chk("rxprog_gated", receive_program_data, 0);
                @(negedge clk);
            end
            chk("settle_state", boot_state, 3);
            @(negedge clk);
        end
        if (boot_state == 3'd4) begin
            chk("txaa_req", {receive_program_data, transmit_0xAA}, 2'b01);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            transmit_0xAA_finished = 1'b1;
            #1;
            chk("txaa_gated", transmit_0xAA, 0);
            @(negedge clk);
            chk("state_run", boot_state, 5);
        end
        if (boot_state == 3'd5) begin
            chk("run_outs", outs(), 8'b1110_0000);
        end
        if (boot_state == 3'd6) begin
            repeat (2) @(negedge clk);
            chk("error_outs", outs(), 8'b0001_0000);
        end
        st = int'(boot_state);
        wc = int'(program_word_count);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int st;
        int wc;
        int est;
        int ewc;
        int kind;
        logic [31:0] size;
        int strobes;

        total = 0;
        bad = 0;
        reset_n = 1'b0;
        clear_inputs();

        vecs[0] = '{32'd16, 4, 1'b0, 5, 4};
        vecs[1] = '{32'd16, 4, 1'b1, 5, 4};
        vecs[2] = '{32'd0, 0, 1'b0, 5, 0};
        vecs[3] = '{32'd6, 0, 1'b0, 6, 0};
        vecs[4] = '{32'(MAX_LEN + 4), 0, 1'b0, 6, 0};
        vecs[5] = '{32'd16, 3, 1'b0, 6, 3};
        vecs[6] = '{32'd16, 5, 1'b1, 6, 5};
        vecs[7] = '{32'd4, 1, 1'b1, 5, 1};

        for (int i = 0; i < 8; i++) begin
            run_boot(vecs[i].size, vecs[i].strobes, vecs[i].together, st, wc);
            chk($sformatf("vec%0d_state", i), st, vecs[i].exp_state);
            chk($sformatf("vec%0d_wc", i), wc, vecs[i].exp_wc);
        end

        for (int i = 0; i < 10; i++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin size = 32'(4 * $urandom_range(1, 16)); strobes = int'(size / 4); end
                1: begin
                    size = 32'(4 * $urandom_range(2, 16));
                    strobes = int'(size / 4) + (($urandom_range(0, 1) == 1) ? 1 : -1);
                end
                2: begin size = 32'(4 * $urandom_range(1, 16) + $urandom_range(1, 3)); strobes = 0; end
                3: begin size = 32'(MAX_LEN + 4 * $urandom_range(1, 1000)); strobes = 0; end
                default: begin size = 32'd0; strobes = 0; end
            endcase
            model(size, strobes, est, ewc);
            run_boot(size, strobes, $urandom_range(0, 1) == 1, st, wc);
            chk($sformatf("rnd%0d_state", i), st, est);
            chk($sformatf("rnd%0d_wc", i), wc, ewc);
        end

        // Reset asserted mid-cycle during the program load.
        apply_reset();
        wait_idle("idle_len_pre");
        transmit_0x99_finished = 1'b1;
        @(negedge clk);
        program_data_size = 32'd16;
        receive_program_data_size_finished = 1'b1;
        @(negedge clk);
        chk("mid_state_rxprog", boot_state, 3);
        repeat (2) begin
            program_memory_write_enable = 1'b1;
            @(negedge clk);
            program_memory_write_enable = 1'b0;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outs", {outs(), 5'd0, boot_state}, 16'd0);
        chk("mid_reset_wc", program_word_count, 0);
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle("idle_len_post");
        chk("fresh_tx99", transmit_0x99, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
